// File: rtl/fifo_lvl.sv
// fifo_lvl: single-clock FIFO with a registered fill level, programmable
// almost-full / almost-empty thresholds, sticky overflow/underflow flags
// and a synchronous flush. DEPTH need not be a power of two.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   flush                   synchronous empty request (pointers/level to 0)
//   clear_err               clears overflow/underflow (a new error wins)
//   in_shift, in_data       push request and data
//   in_full, in_afull       level == DEPTH, level >= AFULL_LVL
//   out_pop, out_data       pop request and read data
//   out_nempty, out_aempty  level != 0, level <= AEMPTY_LVL
//   level                   words stored, 0..DEPTH
//   overflow, underflow     sticky error flags
//
// Configuration macro: FIFO_LVL_FWFT_EN
//   defined   -> first-word-fall-through, out_data = memory[rd_ptr]
//   undefined -> registered read, out_data loads on the accepting edge
module fifo_lvl #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned AFULL_LVL  = DEPTH - 1,
    parameter int unsigned AEMPTY_LVL = 1,
    localparam int unsigned LW        = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             clear_err,
    input  logic             in_shift,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_full,
    output logic             in_afull,
    input  logic             out_pop,
    output logic [WIDTH-1:0] out_data,
    output logic             out_nempty,
    output logic             out_aempty,
    output logic [LW-1:0]    level,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    logic          push_ok;
    logic          pop_ok;
    logic [LW-1:0] level_nxt;
    logic          ovf_nxt;
    logic          unf_nxt;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Acceptance uses the registered flags, so a simultaneous push and pop
    // at full/empty resolves to exactly one accepted operation.
    always_comb begin
        push_ok   = in_shift && !in_full && !flush;
        pop_ok    = out_pop && out_nempty && !flush;
        level_nxt = level;
        if (flush) begin
            level_nxt = '0;
        end else if (push_ok && !pop_ok) begin
            level_nxt = level + LW'(1);
        end else if (pop_ok && !push_ok) begin
            level_nxt = level - LW'(1);
        end
        // Error set has priority over clear; flush suppresses new errors.
        ovf_nxt = (overflow && !clear_err) || (!flush && in_shift && in_full);
        unf_nxt = (underflow && !clear_err) || (!flush && out_pop && !out_nempty);
    end

    // Flags are computed from the next level so they register alongside it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            in_full    <= 1'b0;
            in_afull   <= 1'b0;
            out_nempty <= 1'b0;
            out_aempty <= 1'b1;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= bump(wr_ptr);
                if (pop_ok)  rd_ptr <= bump(rd_ptr);
            end
            level      <= level_nxt;
            in_full    <= (level_nxt == LW'(DEPTH));
            in_afull   <= (level_nxt >= LW'(AFULL_LVL));
            out_nempty <= (level_nxt != '0);
            out_aempty <= (level_nxt <= LW'(AEMPTY_LVL));
            overflow   <= ovf_nxt;
            underflow  <= unf_nxt;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= in_data;
    end

`ifdef FIFO_LVL_FWFT_EN
    assign out_data = mem[rd_ptr];
`else
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_data <= '0;
        end else if (pop_ok) begin
            out_data <= mem[rd_ptr];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_lvl.sv
module tb_fifo_lvl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    // DEPTH=4 instance signals
    logic        flush = 1'b0, clear_err = 1'b0, in_shift = 1'b0, out_pop = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_full, in_afull, out_nempty, out_aempty, overflow, underflow;
    logic [15:0] out_data;
    logic [2:0]  level;

    // DEPTH=5 instance signals
    logic        flush5 = 1'b0, clear5 = 1'b0, shift5 = 1'b0, pop5 = 1'b0;
    logic [15:0] din5 = '0;
    logic        full5, afull5, nempty5, aempty5, ovf5, unf5;
    logic [15:0] dout5;
    logic [2:0]  lvl5;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clock = ~clock;

    fifo_lvl #(.WIDTH(16), .DEPTH(4)) dut (
        .clock(clock), .reset(reset), .flush(flush), .clear_err(clear_err),
        .in_shift(in_shift), .in_data(in_data), .in_full(in_full), .in_afull(in_afull),
        .out_pop(out_pop), .out_data(out_data), .out_nempty(out_nempty),
        .out_aempty(out_aempty), .level(level), .overflow(overflow), .underflow(underflow)
    );

    fifo_lvl #(.WIDTH(16), .DEPTH(5)) dut5 (
        .clock(clock), .reset(reset), .flush(flush5), .clear_err(clear5),
        .in_shift(shift5), .in_data(din5), .in_full(full5), .in_afull(afull5),
        .out_pop(pop5), .out_data(dout5), .out_nempty(nempty5),
        .out_aempty(aempty5), .level(lvl5), .overflow(ovf5), .underflow(unf5)
    );

    typedef struct {
        logic        fl, ce, sh;
        logic [15:0] din;
        logic        pp;
        logic [2:0]  lvl;
        logic        full, afull, ne, ae, ov, un;
        logic [15:0] dout;
    } vec_t;

    vec_t vt[28];

    function automatic vec_t mk(logic fl, logic ce, logic sh, logic [15:0] din, logic pp,
                                logic [2:0] lvl, logic full, logic afull, logic ne,
                                logic ae, logic ov, logic un, logic [15:0] dout);
        vec_t v;
        v.fl = fl; v.ce = ce; v.sh = sh; v.din = din; v.pp = pp;
        v.lvl = lvl; v.full = full; v.afull = afull; v.ne = ne; v.ae = ae;
        v.ov = ov; v.un = un; v.dout = dout;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " level"},      32'(level), 32'd0);
        check({tag, " in_full"},    32'(in_full), 32'd0);
        check({tag, " in_afull"},   32'(in_afull), 32'd0);
        check({tag, " out_nempty"}, 32'(out_nempty), 32'd0);
        check({tag, " out_aempty"}, 32'(out_aempty), 32'd1);
        check({tag, " overflow"},   32'(overflow), 32'd0);
        check({tag, " underflow"},  32'(underflow), 32'd0);
        check({tag, " out_data"},   32'(out_data), 32'd0);
    endtask

    initial begin
        //        fl ce sh din      pp  lvl f af ne ae ov un dout
        vt[0]  = mk(0, 0, 1, 16'h0001, 0, 1, 0, 0, 1, 1, 0, 0, 16'h0000);
        vt[1]  = mk(0, 0, 1, 16'h0002, 0, 2, 0, 0, 1, 0, 0, 0, 16'h0000);
        vt[2]  = mk(0, 0, 1, 16'h0003, 0, 3, 0, 1, 1, 0, 0, 0, 16'h0000);
        vt[3]  = mk(0, 0, 1, 16'h0004, 0, 4, 1, 1, 1, 0, 0, 0, 16'h0000);
        vt[4]  = mk(0, 0, 1, 16'hBEEF, 0, 4, 1, 1, 1, 0, 1, 0, 16'h0000);
        vt[5]  = mk(0, 0, 0, 16'h0000, 1, 3, 0, 1, 1, 0, 1, 0, 16'h0001);
        vt[6]  = mk(0, 0, 0, 16'h0000, 1, 2, 0, 0, 1, 0, 1, 0, 16'h0002);
        vt[7]  = mk(0, 0, 0, 16'h0000, 1, 1, 0, 0, 1, 1, 1, 0, 16'h0003);
        vt[8]  = mk(0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 1, 1, 0, 16'h0004);
        vt[9]  = mk(0, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0004);
        vt[10] = mk(0, 0, 1, 16'h00AA, 1, 1, 0, 0, 1, 1, 0, 1, 16'h0004);
        vt[11] = mk(0, 1, 0, 16'h0000, 0, 1, 0, 0, 1, 1, 0, 0, 16'h0004);
        vt[12] = mk(0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 1, 0, 0, 16'h00AA);
        vt[13] = mk(0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 1, 0, 1, 16'h00AA);
        vt[14] = mk(0, 1, 0, 16'h0000, 1, 0, 0, 0, 0, 1, 0, 1, 16'h00AA);
        vt[15] = mk(0, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 16'h00AA);
        vt[16] = mk(0, 0, 1, 16'h0010, 0, 1, 0, 0, 1, 1, 0, 0, 16'h00AA);
        vt[17] = mk(0, 0, 1, 16'h0011, 0, 2, 0, 0, 1, 0, 0, 0, 16'h00AA);
        vt[18] = mk(0, 0, 1, 16'h0012, 0, 3, 0, 1, 1, 0, 0, 0, 16'h00AA);
        vt[19] = mk(0, 0, 1, 16'h0013, 0, 4, 1, 1, 1, 0, 0, 0, 16'h00AA);
        vt[20] = mk(0, 0, 1, 16'h0E0E, 1, 3, 0, 1, 1, 0, 1, 0, 16'h0010);
        vt[21] = mk(0, 1, 0, 16'h0000, 0, 3, 0, 1, 1, 0, 0, 0, 16'h0010);
        vt[22] = mk(0, 0, 1, 16'h0014, 1, 3, 0, 1, 1, 0, 0, 0, 16'h0011);
        vt[23] = mk(1, 0, 1, 16'h0015, 1, 0, 0, 0, 0, 1, 0, 0, 16'h0011);
        vt[24] = mk(0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 1, 0, 1, 16'h0011);
        vt[25] = mk(0, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0011);
        vt[26] = mk(0, 0, 1, 16'h0055, 0, 1, 0, 0, 1, 1, 0, 0, 16'h0011);
        vt[27] = mk(0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 1, 0, 0, 16'h0055);

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_reset_state("reset");
        check("reset dut5 level", 32'(lvl5), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Table-driven DEPTH=4 sequence
        for (int i = 0; i < 28; i++) begin
            @(negedge clock);
            flush = vt[i].fl; clear_err = vt[i].ce; in_shift = vt[i].sh;
            in_data = vt[i].din; out_pop = vt[i].pp;
            @(posedge clock);
            #1;
            check($sformatf("v%0d level", i),      32'(level), 32'(vt[i].lvl));
            check($sformatf("v%0d in_full", i),    32'(in_full), 32'(vt[i].full));
            check($sformatf("v%0d in_afull", i),   32'(in_afull), 32'(vt[i].afull));
            check($sformatf("v%0d out_nempty", i), 32'(out_nempty), 32'(vt[i].ne));
            check($sformatf("v%0d out_aempty", i), 32'(out_aempty), 32'(vt[i].ae));
            check($sformatf("v%0d overflow", i),   32'(overflow), 32'(vt[i].ov));
            check($sformatf("v%0d underflow", i),  32'(underflow), 32'(vt[i].un));
            check($sformatf("v%0d out_data", i),   32'(out_data), 32'(vt[i].dout));
        end
        @(negedge clock);
        flush = 1'b0; clear_err = 1'b0; in_shift = 1'b0; out_pop = 1'b0;

        // DEPTH=5: preload two words, then 12 push/pop pairs (pointers wrap twice)
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            shift5 = 1'b1; din5 = 16'(k);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            shift5 = 1'b1; din5 = 16'(k + 2); pop5 = 1'b1;
            @(posedge clock);
            #1;
            check($sformatf("d5 pair%0d level", k), 32'(lvl5), 32'd2);
            check($sformatf("d5 pair%0d data", k),  32'(dout5), 32'(k));
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            shift5 = 1'b0; pop5 = 1'b1;
            @(posedge clock);
            #1;
            check($sformatf("d5 drain%0d data", k),  32'(dout5), 32'(12 + k));
            check($sformatf("d5 drain%0d level", k), 32'(lvl5), 32'(1 - k));
        end
        @(negedge clock);
        pop5 = 1'b0;
        @(posedge clock);
        #1;
        check("d5 errors", {30'd0, ovf5, unf5}, 32'd0);

        // Asynchronous reset in the middle of a push burst
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            in_shift = 1'b1; in_data = 16'h0100 + 16'(k);
        end
        @(posedge clock);
        #1;
        check("burst level", 32'(level), 32'd3);
        @(negedge clock);
        out_pop = 1'b1;
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("async reset");
        @(negedge clock);
        out_pop = 1'b0; in_shift = 1'b1; in_data = 16'h0077;
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("post-reset push level", 32'(level), 32'd1);
        check("post-reset nempty", 32'(out_nempty), 32'd1);
        @(negedge clock);
        in_shift = 1'b0; out_pop = 1'b1;
        @(posedge clock);
        #1;
        check("post-reset pop data", 32'(out_data), 32'h0077);
        check("post-reset pop level", 32'(level), 32'd0);
        @(negedge clock);
        out_pop = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_lvl.md
# fifo_lvl

Parametrised single-clock FIFO with a registered fill level, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. It is the general-purpose buffer between the host-side command/data path and the protocol engines, replacing the fixed-flag FIFO wherever software needs occupancy or threshold status. Depth need not be a power of two.

## Interface
- WIDTH, 16, data word width in bits (>=1)
- DEPTH, 4, number of storage words (>=2, any integer)
- AFULL_LVL, DEPTH-1, in_afull asserts when level >= AFULL_LVL (1..DEPTH)
- AEMPTY_LVL, 1, out_aempty asserts when level <= AEMPTY_LVL (0..DEPTH-1)
- LW, $clog2(DEPTH+1), localparam: level width

- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- flush  in  1  synchronous empty request
- clear_err  in  1  clears overflow/underflow
- in_shift  in  1  push request
- in_data  in  WIDTH  push data
- in_full  out  1  level == DEPTH
- in_afull  out  1  level >= AFULL_LVL
- out_pop  in  1  pop request
- out_data  out  WIDTH  read data
- out_nempty  out  1  level != 0
- out_aempty  out  1  level <= AEMPTY_LVL
- level  out  LW  words stored, 0..DEPTH
- overflow  out  1  sticky: push attempted while in_full
- underflow  out  1  sticky: pop attempted while !out_nempty

## Operation
- Reset values: level 0, in_full 0, in_afull 0 (1 if AFULL_LVL==0 is illegal, so 0), out_nempty 0, out_aempty 1, overflow 0, underflow 0, out_data 0, both pointers 0.
- Push accepted iff in_shift && !in_full; writes memory[wr_ptr], wr_ptr advances, wraps DEPTH-1 -> 0.
- Pop accepted iff out_pop && out_nempty; rd_ptr advances with same wrap.
- Acceptance uses flag values sampled at the edge (pre-update): push and pop in the same cycle are both accepted when 0 < level < DEPTH; level unchanged.
- Full + push + pop: pop accepted, push rejected, overflow set, level DEPTH-1.
- Empty + push + pop: push accepted, pop rejected, underflow set, level 1.
- level: +1 push only, -1 pop only, else hold. Never exceeds DEPTH or goes below 0.
- flush: highest priority after reset; pointers and level to 0, flags to empty state, push/pop that cycle ignored and do not set error flags; out_data and error flags hold.
- clear_err clears both sticky flags; a new error in the same cycle wins (flag reads 1).
- Memory contents are not reset.

## Timing
- All outputs registered (except out_data in FWFT); flags and level reflect post-edge state in the cycle after the causing edge.
- Push-to-out_nempty latency: 1 cycle.
- Non-FWFT read: out_data loads memory[rd_ptr] on the edge that accepts the pop; valid from the following cycle, held until the next accepted pop.
- Back-to-back push every cycle fills DEPTH words in DEPTH cycles; in_full rises the cycle after the DEPTH-th push.
- Reset deassertion mid-operation: FIFO is empty; first push accepted on first edge after release.

## Configuration
- FIFO_LVL_FWFT_EN defined: first-word-fall-through; out_data = memory[rd_ptr] combinationally, valid whenever out_nempty; accepted pop advances to next word; out_data undefined while empty.
- Undefined: registered-read mode described under Timing.

## Test plan
- Reset, then push 0x0001..0x0004 (DEPTH=4) on 4 consecutive cycles -> level 1,2,3,4; in_full 1 after 4th; in_afull 1 from level 3; out_aempty 0 from level 2.
- Full, assert in_shift with 0xBEEF 1 cycle -> overflow 1, level stays 4; pop all -> data 0x0001..0x0004 in order (1-cycle lag non-FWFT, immediate in FWFT), no 0xBEEF.
- Empty, push 0x00AA and pop same cycle -> underflow 1, level 1; clear_err -> underflow 0; next pop returns 0x00AA.
- DEPTH=5: 12 push/pop pairs at level 2 -> pointers wrap twice, level stays 2, data order preserved.
- Level 3, flush with in_shift and out_pop high -> level 0, out_nempty 0, no error flags; reset asserted mid-burst -> all outputs to reset values asynchronously.
